// File: rtl/huffman_pkg.sv
// Shared types and constants for the serial Huffman/coefficient encoder.
package huffman_pkg;

   localparam int MAX_CODE_LEN   = 9;
   localparam int COEF_W         = 10;
   localparam int MAX_COEFF_SIZE = 10;
   localparam int LEN_W          = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CODE = 2'd1,
      ST_COEF = 2'd2
   } state_t;

   // Negative coefficients are sent as one's complement (value - 1); the
   // serializer keeps only the low coeff_size bits of the result.
   function automatic logic [COEF_W-1:0] coef_magnitude(input logic [COEF_W-1:0] coef);
      return coef[COEF_W-1] ? (coef - COEF_W'(1)) : coef;
   endfunction

endpackage

// File: rtl/huffman_encoder_if.sv
// Symbol-in / bitstream-out bundle of the Huffman encoder, including the code table lookup.
interface huffman_encoder_if;
   import huffman_pkg::*;

   logic                    sym_valid_s1;
   logic                    sym_ready_s1;
   logic [LEN_W-1:0]        run_length_s1;
   logic [LEN_W-1:0]        coeff_size_s1;
   logic [COEF_W-1:0]       coefficient_s1;
   logic [2*LEN_W-1:0]      table_addr_s1;
   logic [MAX_CODE_LEN-1:0] code_v1;
   logic [LEN_W-1:0]        code_len_v1;
   logic                    bitstream_s1;
   logic                    bit_valid_s1;
   logic                    error_s1;

   modport master (
      output sym_valid_s1, run_length_s1, coeff_size_s1, coefficient_s1, code_v1, code_len_v1,
      input  sym_ready_s1, table_addr_s1, bitstream_s1, bit_valid_s1, error_s1
   );

   modport slave (
      input  sym_valid_s1, run_length_s1, coeff_size_s1, coefficient_s1, code_v1, code_len_v1,
      output sym_ready_s1, table_addr_s1, bitstream_s1, bit_valid_s1, error_s1
   );

endinterface

// File: rtl/bit_serializer.sv
// Loadable MSB-first shift register: the low i_len bits of i_data leave one per shift.
module bit_serializer
   import huffman_pkg::*;
#(
   parameter int W = 9
)
(
   input  logic             phi1,
   input  logic             reset_b,
   input  logic             i_load,
   input  logic [W-1:0]     i_data,
   input  logic [LEN_W-1:0] i_len,
   input  logic             i_shift,
   output logic             o_bit,
   output logic             o_last,
   output logic             o_busy
);

   logic [W-1:0]     r_shift;
   logic [LEN_W-1:0] r_cnt;
   logic [LEN_W:0]   w_pad;
   logic [W-1:0]     w_aligned;

   // Left-align the field so the MSB to send sits at the top; bits above i_len fall off.
   assign w_pad     = (LEN_W+1)'(W) - {1'b0, i_len};
   assign w_aligned = i_data << w_pad;

   always_ff @(posedge phi1) begin
      if (!reset_b) begin
         r_shift <= '0;
         r_cnt   <= '0;
      end else if (i_load) begin
         r_shift <= w_aligned;
         r_cnt   <= i_len;
      end else if (i_shift && (r_cnt != '0)) begin
         r_shift <= {r_shift[W-2:0], 1'b0};
         r_cnt   <= r_cnt - LEN_W'(1);
      end
   end

   assign o_bit  = r_shift[W-1];
   assign o_last = (r_cnt == LEN_W'(1));
   assign o_busy = (r_cnt != '0);

endmodule

// File: rtl/huffman_encoder.sv
// Serializes Huffman code then coefficient magnitude bits per symbol, with back-to-back
// acceptance on the final bit and a sticky flag for illegal code/size combinations.
module huffman_encoder
   import huffman_pkg::*;
(
   input  logic              phi1,
   input  logic              reset_b,
   huffman_encoder_if.slave  bus
);

   state_t            r_state;
   state_t            w_state_next;
   logic              r_error;
   logic              w_error_next;
   logic              w_xfer;
   logic              w_illegal;
   logic              w_final;
   logic              w_load;
   logic              w_ready;
   logic              w_code_bit;
   logic              w_code_last;
   logic              w_code_busy;
   logic              w_coef_bit;
   logic              w_coef_last;
   logic              w_coef_busy;
   logic [COEF_W-1:0] w_coef_mag;

   assign bus.table_addr_s1 = {bus.run_length_s1, bus.coeff_size_s1};
   assign w_coef_mag        = coef_magnitude(bus.coefficient_s1);

   assign w_illegal = (bus.code_len_v1 == '0)
                   || (bus.code_len_v1   > LEN_W'(MAX_CODE_LEN))
                   || (bus.coeff_size_s1 > LEN_W'(MAX_COEFF_SIZE));

   // The final bit of a symbol is the last code bit when there is no coefficient field.
   assign w_final = ((r_state == ST_CODE) && w_code_last && !w_coef_busy)
                 || ((r_state == ST_COEF) && w_coef_last);

   assign w_ready          = (r_state == ST_IDLE) || w_final;
   assign bus.sym_ready_s1 = w_ready;
   assign w_xfer           = bus.sym_valid_s1 && w_ready;
   assign w_load           = w_xfer && !w_illegal;

   bit_serializer #(.W(MAX_CODE_LEN)) u_code_ser (
      .phi1    (phi1),
      .reset_b (reset_b),
      .i_load  (w_load),
      .i_data  (bus.code_v1),
      .i_len   (bus.code_len_v1),
      .i_shift (r_state == ST_CODE),
      .o_bit   (w_code_bit),
      .o_last  (w_code_last),
      .o_busy  (w_code_busy)
   );

   bit_serializer #(.W(COEF_W)) u_coef_ser (
      .phi1    (phi1),
      .reset_b (reset_b),
      .i_load  (w_load),
      .i_data  (w_coef_mag),
      .i_len   (bus.coeff_size_s1),
      .i_shift (r_state == ST_COEF),
      .o_bit   (w_coef_bit),
      .o_last  (w_coef_last),
      .o_busy  (w_coef_busy)
   );

   always_ff @(posedge phi1) begin
      if (!reset_b) begin
         r_state <= ST_IDLE;
         r_error <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_error <= w_error_next;
      end
   end

   always_comb begin
      w_state_next     = r_state;
      w_error_next     = r_error;
      bus.bit_valid_s1 = 1'b0;
      bus.bitstream_s1 = 1'b0;
      case (r_state)
         ST_IDLE: ;
         ST_CODE: begin
            bus.bit_valid_s1 = w_code_busy;
            bus.bitstream_s1 = w_code_bit;
            if (w_code_last) begin
               w_state_next = w_coef_busy ? ST_COEF : ST_IDLE;
            end
         end
         ST_COEF: begin
            bus.bit_valid_s1 = w_coef_busy;
            bus.bitstream_s1 = w_coef_bit;
            if (w_coef_last) begin
               w_state_next = ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
      // A transfer only happens in IDLE or on a final bit, so it overrides the above.
      if (w_xfer) begin
         if (w_illegal) begin
            w_state_next = ST_IDLE;
            w_error_next = 1'b1;
         end else begin
            w_state_next = ST_CODE;
         end
      end
   end

   assign bus.error_s1 = r_error;

endmodule

// File: tb/tb_huffman_encoder.sv
// Directed-vector bench for huffman_encoder with hand-computed bit sequences.
module tb_huffman_encoder;

   logic phi1    = 1'b0;
   logic reset_b = 1'b0;
   int   n_vec   = 0;
   int   n_err   = 0;

   huffman_encoder_if bus();

   huffman_encoder dut (
      .phi1    (phi1),
      .reset_b (reset_b),
      .bus     (bus)
   );

   always #5 phi1 = ~phi1;

   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end else begin
         $display("ok   %s: %0h", tag, obs);
      end
   endtask

   task automatic tick();
      @(posedge phi1);
      #1;
   endtask

   task automatic offer(input logic [8:0] code, input logic [3:0] len, input logic [3:0] run,
                        input logic [3:0] size, input logic [9:0] coef);
      bus.code_v1        = code;
      bus.code_len_v1    = len;
      bus.run_length_s1  = run;
      bus.coeff_size_s1  = size;
      bus.coefficient_s1 = coef;
      bus.sym_valid_s1   = 1'b1;
   endtask

   task automatic check_idle(input string tag);
      check_value({tag, "_idle_valid"}, 32'(bus.bit_valid_s1), 32'd0);
      check_value({tag, "_idle_bit"},   32'(bus.bitstream_s1), 32'd0);
      check_value({tag, "_idle_ready"}, 32'(bus.sym_ready_s1), 32'd1);
   endtask

   // bits/rdy hold the expected sequence MSB first: index n-1 is the first cycle.
   task automatic expect_bits(input string tag, input int n, input logic [31:0] bits,
                              input logic [31:0] rdy);
      logic was_ready;
      for (int i = 0; i < n; i++) begin
         check_value($sformatf("%s_valid%0d", tag, i), 32'(bus.bit_valid_s1), 32'd1);
         check_value($sformatf("%s_bit%0d", tag, i),   32'(bus.bitstream_s1), 32'(bits[n-1-i]));
         check_value($sformatf("%s_ready%0d", tag, i), 32'(bus.sym_ready_s1), 32'(rdy[n-1-i]));
         was_ready = bus.sym_ready_s1;
         tick();
         if (was_ready) bus.sym_valid_s1 = 1'b0;
      end
   endtask

   initial begin
      bus.sym_valid_s1   = 1'b0;
      bus.run_length_s1  = '0;
      bus.coeff_size_s1  = '0;
      bus.coefficient_s1 = '0;
      bus.code_v1        = '0;
      bus.code_len_v1    = '0;

      repeat (2) tick();
      check_value("rst_valid", 32'(bus.bit_valid_s1), 32'd0);
      check_value("rst_bit",   32'(bus.bitstream_s1), 32'd0);
      check_value("rst_error", 32'(bus.error_s1),     32'd0);
      check_value("rst_ready", 32'(bus.sym_ready_s1), 32'd1);
      reset_b = 1'b1;
      tick();

      // code 101, size 2, +3 -> 1 0 1 1 1
      offer(9'b101, 4'd3, 4'd5, 4'd2, 10'd3);
      #1;
      check_value("pos_taddr", 32'(bus.table_addr_s1), 32'h52);
      tick();
      bus.sym_valid_s1 = 1'b0;
      expect_bits("pos", 5, 32'b10111, 32'b00001);
      check_idle("pos");

      // code 101, size 2, -2 -> one's complement 01 -> 1 0 1 0 1
      offer(9'b101, 4'd3, 4'd0, 4'd2, 10'h3FE);
      tick();
      bus.sym_valid_s1 = 1'b0;
      expect_bits("neg", 5, 32'b10101, 32'b00001);
      check_idle("neg");

      // code 00, size 0 -> 0 0, ready on the second bit
      offer(9'b00, 4'd2, 4'd0, 4'd0, 10'd0);
      tick();
      bus.sym_valid_s1 = 1'b0;
      expect_bits("sz0", 2, 32'b00, 32'b01);
      check_idle("sz0");

      // +13 with size 2 keeps only the low bits 01
      offer(9'b1, 4'd1, 4'd0, 4'd2, 10'd13);
      tick();
      bus.sym_valid_s1 = 1'b0;
      expect_bits("trunc", 3, 32'b101, 32'b001);
      check_idle("trunc");

      // 19-bit symbol: code 1A5 len 9, size 10, -300 -> 0x2D3
      offer(9'h1A5, 4'd9, 4'd0, 4'd10, 10'h2D4);
      tick();
      bus.sym_valid_s1 = 1'b0;
      expect_bits("max", 19, {13'd0, 9'h1A5, 10'h2D3}, 32'd1);
      check_idle("max");

      // back-to-back: A = 11 + 1, B = 0110 + (-5 -> 010), valid held
      offer(9'b11, 4'd2, 4'd0, 4'd1, 10'd1);
      tick();
      offer(9'b0110, 4'd4, 4'd0, 4'd3, 10'h3FB);
      expect_bits("b2b", 10, 32'b1110110010, 32'b0010000001);
      check_idle("b2b");

      // code_len 0: consumed, no bits, sticky error
      offer(9'b1, 4'd0, 4'd0, 4'd0, 10'd0);
      tick();
      bus.sym_valid_s1 = 1'b0;
      check_value("len0_valid", 32'(bus.bit_valid_s1), 32'd0);
      check_value("len0_error", 32'(bus.error_s1),     32'd1);
      check_value("len0_ready", 32'(bus.sym_ready_s1), 32'd1);
      repeat (3) tick();
      check_value("len0_sticky", 32'(bus.error_s1),     32'd1);
      check_value("len0_quiet",  32'(bus.bit_valid_s1), 32'd0);

      // coeff_size 11 is illegal too
      offer(9'b1, 4'd1, 4'd0, 4'd11, 10'd0);
      tick();
      bus.sym_valid_s1 = 1'b0;
      check_value("sz11_valid", 32'(bus.bit_valid_s1), 32'd0);
      check_value("sz11_error", 32'(bus.error_s1),     32'd1);

      // legal symbol still flows with the error flag set
      offer(9'b1, 4'd1, 4'd0, 4'd0, 10'd0);
      tick();
      bus.sym_valid_s1 = 1'b0;
      expect_bits("after_err", 1, 32'b1, 32'b1);
      check_value("after_err_flag", 32'(bus.error_s1), 32'd1);

      // reset during the third code bit of 10110
      offer(9'b10110, 4'd5, 4'd0, 4'd0, 10'd0);
      tick();
      bus.sym_valid_s1 = 1'b0;
      check_value("mid_bit0", 32'(bus.bitstream_s1), 32'd1);
      tick();
      check_value("mid_bit1", 32'(bus.bitstream_s1), 32'd0);
      tick();
      check_value("mid_valid2", 32'(bus.bit_valid_s1), 32'd1);
      check_value("mid_bit2",   32'(bus.bitstream_s1), 32'd1);
      reset_b = 1'b0;
      offer(9'b1, 4'd1, 4'd0, 4'd0, 10'd0);
      tick();
      check_value("rst2_valid", 32'(bus.bit_valid_s1), 32'd0);
      check_value("rst2_bit",   32'(bus.bitstream_s1), 32'd0);
      check_value("rst2_error", 32'(bus.error_s1),     32'd0);
      check_value("rst2_ready", 32'(bus.sym_ready_s1), 32'd1);
      bus.sym_valid_s1 = 1'b0;
      reset_b = 1'b1;
      tick();
      check_value("rst2_noaccept", 32'(bus.bit_valid_s1), 32'd0);
      check_value("rst2_error_hold", 32'(bus.error_s1), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
